// File: rtl/traffic_ctrl_param.sv
// Two-road traffic-light controller with its own phase timer, all-red clearance,
// pedestrian green shortening and a night flashing-yellow mode.
module traffic_ctrl_param #(
  parameter int unsigned CNT_W     = 6,
  parameter int unsigned GREEN_NS  = 45,
  parameter int unsigned GREEN_EW  = 30,
  parameter int unsigned YELLOW    = 3,
  parameter int unsigned ALL_RED   = 1,
  parameter int unsigned PED_GREEN = 5
) (
  input  logic             clk1,
  input  logic             clr,
  input  logic             tick,
  input  logic             ped_req,
  input  logic             night,
  output logic [5:0]       lights,
  output logic [CNT_W-1:0] remain,
  output logic [2:0]       phase
);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    AR1   = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    AR2   = 3'd5,
    FLASH = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] LD_NS  = CNT_W'(GREEN_NS - 1);
  localparam logic [CNT_W-1:0] LD_EW  = CNT_W'(GREEN_EW - 1);
  localparam logic [CNT_W-1:0] LD_Y   = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_AR  = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] LD_PED = CNT_W'(PED_GREEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             flash_q, flash_d;
  logic             ped_q, ped_d;

  function automatic state_t next_of(input state_t s);
    case (s)
      NS_G:    next_of = NS_Y;
      NS_Y:    next_of = AR1;
      AR1:     next_of = EW_G;
      EW_G:    next_of = EW_Y;
      EW_Y:    next_of = AR2;
      default: next_of = NS_G;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] dur_m1(input state_t s);
    case (s)
      NS_G:       dur_m1 = LD_NS;
      EW_G:       dur_m1 = LD_EW;
      NS_Y, EW_Y: dur_m1 = LD_Y;
      AR1, AR2:   dur_m1 = LD_AR;
      default:    dur_m1 = '0;
    endcase
  endfunction

  always_ff @(posedge clk1 or posedge clr) begin
    if (clr) begin
      state_q  <= NS_G;
      remain_q <= LD_NS;
      flash_q  <= 1'b0;
      ped_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      flash_q  <= flash_d;
      ped_q    <= ped_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    flash_d  = flash_q;
    // The unused code 7 recovers without waiting for a tick.
    if (3'(state_q) == 3'd7) begin
      state_d  = AR2;
      remain_d = LD_AR;
    end else if (tick) begin
      if (night && state_q != FLASH) begin
        state_d  = FLASH;
        remain_d = '0;
        flash_d  = 1'b0;
      end else if (state_q == FLASH) begin
        if (!night) begin
          state_d  = AR2;
          remain_d = LD_AR;
        end else begin
          flash_d = ~flash_q;
        end
      end else if (remain_q == '0) begin
        state_d  = next_of(state_q);
        remain_d = dur_m1(next_of(state_q));
      end else if ((state_q == NS_G || state_q == EW_G) && ped_q && remain_q > LD_PED) begin
        remain_d = LD_PED;
      end else begin
        remain_d = remain_q - CNT_W'(1);
      end
    end
  end

  // A fresh request outranks a clear landing on the same cycle.
  always_comb begin
    ped_d = ped_q;
    if (state_d != state_q && (state_d == AR1 || state_d == AR2 || state_d == FLASH))
      ped_d = 1'b0;
    if (ped_req)
      ped_d = 1'b1;
  end

  always_comb begin
    case (state_q)
      NS_G:    lights = 6'b100001;
      NS_Y:    lights = 6'b010001;
      EW_G:    lights = 6'b001100;
      EW_Y:    lights = 6'b001010;
      FLASH:   lights = flash_q ? 6'b000000 : 6'b010010;
      default: lights = 6'b001001;
    endcase
  end

  assign remain = remain_q;
  assign phase  = 3'(state_q);

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Directed bench for traffic_ctrl_param with default parameters; ticks every 4 clk1.
module tb_traffic_ctrl_param;

  logic       clk1 = 1'b0;
  logic       clr = 1'b0;
  logic       tick = 1'b0;
  logic       ped_req = 1'b0;
  logic       night = 1'b0;
  logic [5:0] lights;
  logic [5:0] remain;
  logic [2:0] phase;

  int checks = 0;
  int failures = 0;

  traffic_ctrl_param #(
    .CNT_W(6), .GREEN_NS(45), .GREEN_EW(30), .YELLOW(3), .ALL_RED(1), .PED_GREEN(5)
  ) dut (
    .clk1(clk1), .clr(clr), .tick(tick), .ped_req(ped_req), .night(night),
    .lights(lights), .remain(remain), .phase(phase)
  );

  always #5 clk1 = ~clk1;

  // Advance to the next falling edge and check the lamp safety invariant there.
  task automatic step_clk();
    @(negedge clk1);
    checks++;
    if ((phase != 3'd6 && lights[3] == 1'b0 && lights[0] == 1'b0) ||
        $countones(lights[5:3]) > 1 || $countones(lights[2:0]) > 1) begin
      failures++;
      $display("FAIL safety_invariant: lights=%b phase=%0d", lights, phase);
    end
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step_clk();
      tick = 1'b0;
      step_clk();
      step_clk();
      step_clk();
    end
  endtask

  task automatic ped_pulse();
    ped_req = 1'b1;
    step_clk();
    ped_req = 1'b0;
    step_clk();
  endtask

  task automatic do_reset();
    tick = 1'b0; ped_req = 1'b0; night = 1'b0;
    clr = 1'b1;
    step_clk();
    step_clk();
    clr = 1'b0;
    step_clk();
  endtask

  task automatic expect_state(input string name, input logic [2:0] ph, input logic [5:0] rem,
                              input logic [5:0] lt);
    checks++;
    if (phase !== ph || remain !== rem || lights !== lt) begin
      failures++;
      $display("FAIL %s: phase=%0d remain=%0d lights=%b, required phase=%0d remain=%0d lights=%b",
               name, phase, remain, lights, ph, rem, lt);
    end
  endtask

  task automatic test_reset();
    tick = 1'b0; ped_req = 1'b0; night = 1'b0;
    clr = 1'b1;
    step_clk();
    checks++;
    if (phase !== 3'd0 || remain !== 6'd44 || lights !== 6'b100001) begin
      failures++;
      $display("FAIL reset_held: phase=%0d remain=%0d lights=%b, required 0/44/100001",
               phase, remain, lights);
    end
    clr = 1'b0;
    step_clk();
    expect_state("reset_release", 3'd0, 6'd44, 6'b100001);
    do_ticks(44);
    expect_state("ns_g_last_tick", 3'd0, 6'd0, 6'b100001);
    do_ticks(1);
    expect_state("ns_y_entry", 3'd1, 6'd2, 6'b010001);
    do_ticks(3);
    expect_state("ar1_entry", 3'd2, 6'd0, 6'b001001);
    do_ticks(1);
    expect_state("ew_g_entry", 3'd3, 6'd29, 6'b001100);
  endtask

  task automatic test_full_cycle();
    do_reset();
    do_ticks(79);
    expect_state("ew_y_entry", 3'd4, 6'd2, 6'b001010);
    do_ticks(3);
    expect_state("ar2_entry", 3'd5, 6'd0, 6'b001001);
    do_ticks(1);
    expect_state("full_cycle_83", 3'd0, 6'd44, 6'b100001);
  endtask

  task automatic test_ped_shorten();
    do_reset();
    do_ticks(14);
    expect_state("ped_pre", 3'd0, 6'd30, 6'b100001);
    ped_pulse();
    expect_state("ped_no_tick_hold", 3'd0, 6'd30, 6'b100001);
    do_ticks(1);
    expect_state("ped_shortened", 3'd0, 6'd4, 6'b100001);
    do_ticks(4);
    expect_state("ped_last_green", 3'd0, 6'd0, 6'b100001);
    do_ticks(1);
    expect_state("ped_ns_y", 3'd1, 6'd2, 6'b010001);
    do_ticks(4);
    expect_state("ped_ew_g_full", 3'd3, 6'd29, 6'b001100);
    do_ticks(29);
    expect_state("ped_ew_g_end", 3'd3, 6'd0, 6'b001100);
    do_ticks(1);
    expect_state("ped_ew_y", 3'd4, 6'd2, 6'b001010);
  endtask

  task automatic test_late_ped();
    do_reset();
    do_ticks(49 + 27);
    expect_state("late_pre", 3'd3, 6'd2, 6'b001100);
    ped_pulse();
    do_ticks(1);
    expect_state("late_rem1", 3'd3, 6'd1, 6'b001100);
    do_ticks(1);
    expect_state("late_rem0", 3'd3, 6'd0, 6'b001100);
    do_ticks(1);
    expect_state("late_ew_y", 3'd4, 6'd2, 6'b001010);
  endtask

  task automatic test_night();
    do_reset();
    do_ticks(50);
    expect_state("night_pre", 3'd3, 6'd28, 6'b001100);
    night = 1'b1;
    step_clk();
    expect_state("night_no_tick", 3'd3, 6'd28, 6'b001100);
    do_ticks(1);
    expect_state("flash_0", 3'd6, 6'd0, 6'b010010);
    do_ticks(1);
    expect_state("flash_1", 3'd6, 6'd0, 6'b000000);
    do_ticks(1);
    expect_state("flash_2", 3'd6, 6'd0, 6'b010010);
    night = 1'b0;
    do_ticks(1);
    expect_state("night_exit_ar2", 3'd5, 6'd0, 6'b001001);
    do_ticks(1);
    expect_state("night_ns_g", 3'd0, 6'd44, 6'b100001);
  endtask

  task automatic test_async_reset();
    do_reset();
    do_ticks(80);
    expect_state("async_pre", 3'd4, 6'd1, 6'b001010);
    @(posedge clk1);
    #2 clr = 1'b1;
    #1;
    expect_state("async_clr", 3'd0, 6'd44, 6'b100001);
    #1 clr = 1'b0;
    for (int i = 0; i < 100; i++) step_clk();
    expect_state("idle_hold", 3'd0, 6'd44, 6'b100001);
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_ped_shorten();
    test_late_ped();
    test_night();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
